// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared AES core.
// Optional busy-timeout abort is compiled in with `define AES_ARB_TIMEOUT_EN.
module aes_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_enc_dec,
    input  logic [1:0]   req0_mode,
    input  logic [255:0] req0_key,
    input  logic [127:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_enc_dec,
    input  logic [1:0]   req1_mode,
    input  logic [255:0] req1_key,
    input  logic [127:0] req1_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         core_start,
    output logic         core_enc_dec,
    output logic [1:0]   core_mode,
    output logic [255:0] core_key,
    output logic [127:0] core_data_in,
    input  logic [127:0] core_data_out,
    input  logic         core_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t       state_q;
    logic         last_grant_q;
    logic         id_q;
    logic         enc_dec_q;
    logic [1:0]   mode_q;
    logic [255:0] key_q;
    logic [127:0] data_q;
    logic         core_start_q;
    logic         rsp_valid_q;
    logic [127:0] rsp_data_q;

    logic         gnt_vld_d;
    logic         gnt_id_d;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_err_q;
`endif

    // Grant is only offered in IDLE and outside reset; both valid -> the one not served last.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_id_d  = 1'b0;
        if (reset && (state_q == IDLE)) begin
            if (req0_valid && req1_valid) begin
                gnt_vld_d = 1'b1;
                gnt_id_d  = ~last_grant_q;
            end else if (req0_valid) begin
                gnt_vld_d = 1'b1;
                gnt_id_d  = 1'b0;
            end else if (req1_valid) begin
                gnt_vld_d = 1'b1;
                gnt_id_d  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_vld_d && !gnt_id_d;
    assign req1_ready = gnt_vld_d &&  gnt_id_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            enc_dec_q    <= 1'b0;
            mode_q       <= 2'b00;
            key_q        <= '0;
            data_q       <= '0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        id_q         <= gnt_id_d;
                        last_grant_q <= gnt_id_d;
                        enc_dec_q    <= gnt_id_d ? req1_enc_dec : req0_enc_dec;
                        mode_q       <= gnt_id_d ? req1_mode    : req0_mode;
                        key_q        <= gnt_id_d ? req1_key     : req0_key;
                        data_q       <= gnt_id_d ? req1_data    : req0_data;
                        core_start_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    state_q <= BUSY;
`ifdef AES_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                BUSY: begin
                    // core_done wins over a timeout landing in the same cycle.
                    if (core_done) begin
                        rsp_data_q  <= core_data_out;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
`ifdef AES_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_start   = core_start_q;
    assign core_enc_dec = enc_dec_q;
    assign core_mode    = mode_q;
    assign core_key     = key_q;
    assign core_data_in = data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = id_q;
    assign rsp_data     = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule
